// File: rtl/div_seq_top.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Optional DIV_ZERO_DETECT_EN: b==0 short-circuits to a flagged result (dz) instead of iterating.
module div_seq_top #(
  parameter int unsigned WIDTH = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [2*WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_quotient,
  output logic [WIDTH-1:0]     o_remainder,
  output logic                 o_dz
);

  localparam int unsigned CntW = $clog2(2 * WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(2 * WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               r_state, w_state_nx;
  logic [2*WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]     r_dvs;
  logic [WIDTH-1:0]     r_rem;
  logic [CntW-1:0]      r_cnt;
  logic [2*WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]     r_rem_out;

  logic                 w_accept;
  logic                 w_run;
  logic                 w_last;
  logic                 w_zero_b;
  logic [WIDTH:0]       w_rem_sh;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_nx;
  logic [2*WIDTH-1:0]   w_dvd_nx;

  assign w_accept = (r_state == StIdle) && i_start;
  assign w_run    = (r_state == StRun);
  assign w_last   = w_run && (r_cnt == LastCnt);

`ifdef DIV_ZERO_DETECT_EN
  assign w_zero_b = (i_b == '0);
`else
  assign w_zero_b = 1'b0;
`endif

  // Stored remainder is always < divisor after the restore, so its (WIDTH+1)th bit is
  // implicitly zero and only appears in the shifted compare value.
  assign w_rem_sh = {r_rem, r_dvd[2*WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[WIDTH-1:0];
  // Dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
  assign w_dvd_nx = {r_dvd[2*WIDTH-2:0], w_ge};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nx = w_zero_b ? StDone : StRun;
        end
      end
      StRun: begin
        o_busy = 1'b1;
        if (r_cnt == LastCnt) begin
          w_state_nx = StDone;
        end
      end
      StDone: begin
        o_busy     = 1'b1;
        o_done     = 1'b1;
        w_state_nx = StIdle;
      end
      default: w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_dvd <= i_a;
      r_dvs <= i_b;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_run) begin
      r_dvd <= w_dvd_nx;
      r_rem <= w_rem_nx;
      r_cnt <= r_cnt + CntW'(1);
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic r_dz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quo     <= '0;
      r_rem_out <= '0;
      r_dz      <= 1'b0;
    end else if (w_last) begin
      r_quo     <= w_dvd_nx;
      r_rem_out <= w_rem_nx;
      r_dz      <= 1'b0;
    end else if (w_accept && w_zero_b) begin
      r_quo     <= '1;
      r_rem_out <= '0;
      r_dz      <= 1'b1;
    end
  end

  assign o_dz = r_dz;
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quo     <= '0;
      r_rem_out <= '0;
    end else if (w_last) begin
      r_quo     <= w_dvd_nx;
      r_rem_out <= w_rem_nx;
    end
  end

  assign o_dz = 1'b0;
`endif

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem_out;

endmodule

// File: tb/tb_div_seq_top.sv
// Directed, table-driven bench for div_seq_top (WIDTH=6), plus hand sequences for
// ignored start, back-to-back start and mid-operation reset.
module tb_div_seq_top;

  localparam int unsigned W = 6;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2*W-1:0]   a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   quotient;
  logic [W-1:0]     remainder;
  logic             dz;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq_top #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_a         (a),
    .i_b         (b),
    .o_busy      (busy),
    .o_done      (done),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dz;
    int             lat;   // samples after the accepting edge until done is seen
    int             nbusy; // samples with busy high, starting right after the accepting edge
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One operation; optionally pulses start with other operands while busy.
  task automatic run_op(input vec_t v, input bit ign);
    int lat;
    int nbusy;
    int ndone;
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           z;
    lat = -1; nbusy = 0; ndone = 0; q = '0; r = '0; z = 1'b0;
    @(negedge clk);
    start = 1'b1; a = v.a; b = v.b;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~v.a; b = ~v.b;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (ign && k == 3) begin
        start = 1'b1; a = 12'd50; b = 6'd5;
      end
      if (ign && k == 4) start = 1'b0;
      if (done) begin
        ndone++;
        lat = k; q = quotient; r = remainder; z = dz;
      end
      if (busy) nbusy++;
      else break;
    end
    chk("latency", lat, v.lat);
    chk("busy_cycles", nbusy, v.nbusy);
    chk("done_pulses", ndone, 1);
    chk("quotient", q, v.q);
    chk("remainder", r, v.r);
    chk("dz", z, v.dz);
    @(posedge clk);
    #1;
    chk("quotient_hold", quotient, v.q);
  endtask

  initial begin
    int d1, d2;
    logic [2*W-1:0] q1, q2;
    logic [W-1:0]   r1, r2;
    int nspur;

    vecs[0] = '{a: 12'd100,  b: 6'd7,  q: 12'd14,   r: 6'd2, dz: 1'b0, lat: 12, nbusy: 13};
    vecs[1] = '{a: 12'd4095, b: 6'd1,  q: 12'd4095, r: 6'd0, dz: 1'b0, lat: 12, nbusy: 13};
    vecs[2] = '{a: 12'd4095, b: 6'd63, q: 12'd65,   r: 6'd0, dz: 1'b0, lat: 12, nbusy: 13};
    vecs[3] = '{a: 12'd5,    b: 6'd9,  q: 12'd0,    r: 6'd5, dz: 1'b0, lat: 12, nbusy: 13};
`ifdef DIV_ZERO_DETECT_EN
    vecs[4] = '{a: 12'd300,  b: 6'd0,  q: 12'd4095, r: 6'd0, dz: 1'b1, lat: 0, nbusy: 1};
`else
    vecs[4] = '{a: 12'd300,  b: 6'd0,  q: 12'd4095, r: 6'd44, dz: 1'b0, lat: 12, nbusy: 13};
`endif
    vecs[5] = '{a: 12'd1000, b: 6'd10, q: 12'd100,  r: 6'd0, dz: 1'b0, lat: 12, nbusy: 13};
    vecs[6] = '{a: 12'd2000, b: 6'd3,  q: 12'd666,  r: 6'd2, dz: 1'b0, lat: 12, nbusy: 13};
    vecs[7] = '{a: 12'd4094, b: 6'd62, q: 12'd66,   r: 6'd2, dz: 1'b0, lat: 12, nbusy: 13};
    vecs[8] = '{a: 12'd0,    b: 6'd5,  q: 12'd0,    r: 6'd0, dz: 1'b0, lat: 12, nbusy: 13};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dz", dz, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], 1'b0);

    // start pulsed during RUN must be ignored
    run_op(vecs[0], 1'b1);

    // start held high: back-to-back operations
    d1 = -1; d2 = -1; q1 = '0; q2 = '0; r1 = '0; r2 = '0;
    @(negedge clk);
    start = 1'b1; a = 12'd100; b = 6'd7;
    @(posedge clk);
    #1;
    a = 12'd200; b = 6'd13;
    for (int k = 1; k < 36; k++) begin
      @(posedge clk);
      #1;
      if (done && d1 < 0) begin
        d1 = k; q1 = quotient; r1 = remainder;
      end else if (done && d2 < 0) begin
        d2 = k; q2 = quotient; r2 = remainder;
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_done1_time", d1, 12);
    chk("b2b_done2_time", d2, 26);
    chk("b2b_q1", q1, 14);
    chk("b2b_r1", r1, 2);
    chk("b2b_q2", q2, 15);
    chk("b2b_r2", r2, 5);
    for (int k = 0; k < 40 && busy; k++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_idle", busy, 0);

    // reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; a = 12'd100; b = 6'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dz", dz, 0);
    nspur = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) nspur++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) nspur++;
    end
    chk("midrst_spurious", nspur, 0);
    run_op('{a: 12'd200, b: 6'd13, q: 12'd15, r: 6'd5, dz: 1'b0, lat: 12, nbusy: 13}, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
